account_server: RTL and testbench

ACCOUNT_SERVER -- requirements
Module: account_server

---
 rtl/atm_pkg.sv | 41 ++++
 rtl/acct_store.sv | 76 +++++++
 rtl/account_server.sv | 214 +++++++++++++++++++++
 tb/tb_account_server.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/atm_pkg.sv
// Shared definitions for the ATM account server: op codes, response status codes,
// controller state encoding and the default register width.
package atm_pkg;

  localparam int REG_WIDTH_DEF = 12;

  typedef enum logic [2:0] {
    OP_DEP  = 3'b000,
    OP_WD   = 3'b001,
    OP_BAL  = 3'b010,
    OP_XFER = 3'b011,
    OP_AUTH = 3'b100
  } op_e;

  typedef enum logic [2:0] {
    ST_OK      = 3'b000,
    ST_NO_ACCT = 3'b001,
    ST_BAD_PIN = 3'b010,
    ST_LOCKED  = 3'b011,
    ST_INSUFF  = 3'b100,
    ST_NO_DST  = 3'b101,
    ST_BAD_AMT = 3'b110,
    ST_BAD_OP  = 3'b111
  } status_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_LOOKUP = 2'b01,
    S_EXEC   = 2'b10,
    S_RESP   = 2'b11
  } state_e;

  function automatic logic op_is_valid(logic [2:0] op);
    return op <= OP_AUTH;
  endfunction

  function automatic logic op_moves_money(logic [2:0] op);
    return (op == OP_DEP) || (op == OP_WD) || (op == OP_XFER);
  endfunction

endpackage

// File: rtl/acct_store.sv
// Account slot register file: one provisioning write port, one execute port that
// updates a source and a destination slot together, combinational read of one slot.
module acct_store
  import atm_pkg::*;
#(
  parameter int NUM_ACCOUNTS = 4,
  parameter int REG_WIDTH    = REG_WIDTH_DEF,
  localparam int IW          = $clog2(NUM_ACCOUNTS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_we,
  input  logic [IW-1:0]        cfg_idx,
  input  logic [REG_WIDTH-1:0] cfg_acct,
  input  logic [REG_WIDTH-1:0] cfg_pin,
  input  logic [REG_WIDTH-1:0] cfg_bal,
  input  logic                 src_we,
  input  logic [IW-1:0]        src_idx,
  input  logic [REG_WIDTH-1:0] src_bal,
  input  logic [1:0]           src_cnt,
  input  logic                 src_lock,
  input  logic                 dst_we,
  input  logic [IW-1:0]        dst_idx,
  input  logic [REG_WIDTH-1:0] dst_bal,
  input  logic [IW-1:0]        rd_idx,
  output logic                 rd_valid,
  output logic [REG_WIDTH-1:0] rd_acct,
  output logic [REG_WIDTH-1:0] rd_pin,
  output logic [REG_WIDTH-1:0] rd_bal,
  output logic [1:0]           rd_cnt,
  output logic                 rd_lock
);

  logic [NUM_ACCOUNTS-1:0] valid;
  logic [NUM_ACCOUNTS-1:0] lock;
  logic [REG_WIDTH-1:0]    acct [NUM_ACCOUNTS];
  logic [REG_WIDTH-1:0]    pin  [NUM_ACCOUNTS];
  logic [REG_WIDTH-1:0]    bal  [NUM_ACCOUNTS];
  logic [1:0]              cnt  [NUM_ACCOUNTS];

  // Provisioning and execute writes never coincide: the controller only lets cfg through in IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_ACCOUNTS; i++) begin
        valid[i] <= 1'b0;
        lock[i]  <= 1'b0;
        acct[i]  <= '0;
        pin[i]   <= '0;
        bal[i]   <= '0;
        cnt[i]   <= '0;
      end
    end else if (cfg_we) begin
      valid[cfg_idx] <= 1'b1;
      acct[cfg_idx]  <= cfg_acct;
      pin[cfg_idx]   <= cfg_pin;
      bal[cfg_idx]   <= cfg_bal;
      cnt[cfg_idx]   <= '0;
      lock[cfg_idx]  <= 1'b0;
    end else begin
      if (dst_we) bal[dst_idx] <= dst_bal;
      if (src_we) begin
        bal[src_idx]  <= src_bal;
        cnt[src_idx]  <= src_cnt;
        lock[src_idx] <= src_lock;
      end
    end
  end

  assign rd_valid = valid[rd_idx];
  assign rd_acct  = acct[rd_idx];
  assign rd_pin   = pin[rd_idx];
  assign rd_bal   = bal[rd_idx];
  assign rd_cnt   = cnt[rd_idx];
  assign rd_lock  = lock[rd_idx];

endmodule

// File: rtl/account_server.sv
// ATM account server: accepts one request, scans the slot file for source and
// destination accounts, executes the operation in a single commit cycle, then responds.
module account_server
  import atm_pkg::*;
#(
  parameter int NUM_ACCOUNTS = 4,
  parameter int REG_WIDTH    = REG_WIDTH_DEF
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic [2:0]                      req_op,
  input  logic [REG_WIDTH-1:0]            req_acct,
  input  logic [REG_WIDTH-1:0]            req_pin,
  input  logic [REG_WIDTH-1:0]            req_dst,
  input  logic [REG_WIDTH-1:0]            req_amount,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [2:0]                      rsp_status,
  output logic [REG_WIDTH-1:0]            rsp_balance,
  input  logic                            cfg_we,
  input  logic [$clog2(NUM_ACCOUNTS)-1:0] cfg_idx,
  input  logic [REG_WIDTH-1:0]            cfg_acct,
  input  logic [REG_WIDTH-1:0]            cfg_pin,
  input  logic [REG_WIDTH-1:0]            cfg_bal
);

  localparam int W  = REG_WIDTH;
  localparam int IW = $clog2(NUM_ACCOUNTS);
  localparam logic [IW:0] SCAN_END = NUM_ACCOUNTS[IW:0];

  state_e      state;
  logic        idle_q;
  logic [IW:0] scan_idx;
  logic        vld_p0, src_found, dst_found;

  logic [2:0]   op_q;
  logic [W-1:0] acct_q, pin_q, dst_q, amt_q;
  logic          slot_vld_p0, lock_p0;
  logic [IW-1:0] idx_p0;
  logic [W-1:0]  acct_p0, pin_p0, bal_p0;
  logic [1:0]    cnt_p0;
  logic [IW-1:0] src_idx, dst_idx;
  logic [W-1:0]  src_pin, src_bal, dst_bal;
  logic [1:0]    src_cnt;
  logic          src_lock;

  logic          rd_valid, rd_lock;
  logic [W-1:0]  rd_acct, rd_pin, rd_bal;
  logic [1:0]    rd_cnt;

  status_e       ex_status;
  logic          ex_src_we, ex_dst_we, ex_lock;
  logic [W-1:0]  ex_src_bal, ex_dst_bal, ex_rsp_bal;
  logic [1:0]    ex_cnt;
  logic [W:0]    src_sum, dst_sum;

  logic accept, cfg_go, src_hit, dst_hit, exec;

  assign req_ready = idle_q && !cfg_we;
  assign accept    = req_valid && req_ready;
  assign cfg_go    = cfg_we && (state == S_IDLE);
  assign exec      = (state == S_EXEC);
  assign src_hit   = (state == S_LOOKUP) && vld_p0 && slot_vld_p0 && !src_found && (acct_p0 == acct_q);
  assign dst_hit   = (state == S_LOOKUP) && vld_p0 && slot_vld_p0 && !dst_found && (acct_p0 == dst_q);

  acct_store #(.NUM_ACCOUNTS(NUM_ACCOUNTS), .REG_WIDTH(REG_WIDTH)) u_store (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_go), .cfg_idx(cfg_idx), .cfg_acct(cfg_acct), .cfg_pin(cfg_pin), .cfg_bal(cfg_bal),
    .src_we(exec && ex_src_we), .src_idx(src_idx), .src_bal(ex_src_bal), .src_cnt(ex_cnt),
    .src_lock(ex_lock),
    .dst_we(exec && ex_dst_we), .dst_idx(dst_idx), .dst_bal(ex_dst_bal),
    .rd_idx(scan_idx[IW-1:0]), .rd_valid(rd_valid), .rd_acct(rd_acct), .rd_pin(rd_pin),
    .rd_bal(rd_bal), .rd_cnt(rd_cnt), .rd_lock(rd_lock)
  );

  // Scan control: slot k is read into the _p0 stage on one edge and matched on the next,
  // so LOOKUP spends one extra edge draining the final slot before EXEC.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      idle_q      <= 1'b0;
      scan_idx    <= '0;
      vld_p0      <= 1'b0;
      src_found   <= 1'b0;
      dst_found   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_status  <= ST_OK;
      rsp_balance <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          idle_q <= 1'b1;
          if (accept) begin
            state     <= S_LOOKUP;
            idle_q    <= 1'b0;
            scan_idx  <= '0;
            vld_p0    <= 1'b0;
            src_found <= 1'b0;
            dst_found <= 1'b0;
          end
        end
        S_LOOKUP: begin
          vld_p0   <= (scan_idx != SCAN_END);
          scan_idx <= scan_idx + 1'b1;
          if (src_hit) src_found <= 1'b1;
          if (dst_hit) dst_found <= 1'b1;
          if (scan_idx == SCAN_END) state <= S_EXEC;
        end
        S_EXEC: begin
          state       <= S_RESP;
          rsp_valid   <= 1'b1;
          rsp_status  <= ex_status;
          rsp_balance <= ex_rsp_bal;
        end
        S_RESP: begin
          if (rsp_ready) begin
            state     <= S_IDLE;
            rsp_valid <= 1'b0;
            idle_q    <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Request capture, _p0 slot snapshot and matched-slot copies (datapath, no reset)
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q   <= req_op;
      acct_q <= req_acct;
      pin_q  <= req_pin;
      dst_q  <= req_dst;
      amt_q  <= req_amount;
    end
    if (state == S_LOOKUP) begin
      slot_vld_p0 <= rd_valid;
      idx_p0      <= scan_idx[IW-1:0];
      acct_p0     <= rd_acct;
      pin_p0      <= rd_pin;
      bal_p0      <= rd_bal;
      cnt_p0      <= rd_cnt;
      lock_p0     <= rd_lock;
    end
    if (src_hit) begin
      src_idx  <= idx_p0;
      src_pin  <= pin_p0;
      src_bal  <= bal_p0;
      src_cnt  <= cnt_p0;
      src_lock <= lock_p0;
    end
    if (dst_hit) begin
      dst_idx <= idx_p0;
      dst_bal <= bal_p0;
    end
  end

  assign src_sum = {1'b0, src_bal} + {1'b0, amt_q};
  assign dst_sum = {1'b0, dst_bal} + {1'b0, amt_q};

  // EXEC decision: priority-ordered checks, committed to the store on the EXEC edge
  always_comb begin
    ex_status  = ST_OK;
    ex_src_we  = 1'b0;
    ex_dst_we  = 1'b0;
    ex_src_bal = src_bal;
    ex_dst_bal = dst_bal;
    ex_cnt     = src_cnt;
    ex_lock    = src_lock;
    if (!op_is_valid(op_q)) begin
      ex_status = ST_BAD_OP;
    end else if (!src_found) begin
      ex_status = ST_NO_ACCT;
    end else if (src_lock) begin
      ex_status = ST_LOCKED;
    end else if (pin_q != src_pin) begin
      ex_src_we = 1'b1;
      ex_cnt    = src_cnt + 2'd1;
      if (src_cnt == 2'd2) begin
        ex_lock   = 1'b1;
        ex_status = ST_LOCKED;
      end else begin
        ex_status = ST_BAD_PIN;
      end
    end else begin
      ex_src_we = 1'b1;
      ex_cnt    = 2'd0;
      if (op_moves_money(op_q) && (amt_q == '0)) begin
        ex_status = ST_BAD_AMT;
      end else if ((op_q == OP_XFER) && (!dst_found || (dst_idx == src_idx))) begin
        ex_status = ST_NO_DST;
      end else if (((op_q == OP_WD) || (op_q == OP_XFER)) && (amt_q > src_bal)) begin
        ex_status = ST_INSUFF;
      end else if (op_q == OP_DEP) begin
        if (src_sum[W]) ex_status = ST_BAD_AMT;
        else            ex_src_bal = src_sum[W-1:0];
      end else if (op_q == OP_WD) begin
        ex_src_bal = src_bal - amt_q;
      end else if (op_q == OP_XFER) begin
        if (dst_sum[W]) begin
          ex_status = ST_BAD_AMT;
        end else begin
          ex_src_bal = src_bal - amt_q;
          ex_dst_bal = dst_sum[W-1:0];
          ex_dst_we  = 1'b1;
        end
      end
    end
    ex_rsp_bal = (ex_status == ST_OK) ? ex_src_bal : '0;
  end

endmodule

// File: tb/tb_account_server.sv
// Self-checking bench for account_server: directed vector table, hand-written
// handshake/reset sequences, and randomized traffic against a behavioural account model.
module tb_account_server;

  localparam int N  = 4;
  localparam int W  = 12;
  localparam int IW = $clog2(N);
  localparam int LAT = N + 2;
  localparam int MAXBAL = (1 << W) - 1;
  localparam int DEP = 0, WD = 1, BAL = 2, XF = 3, AU = 4;
  localparam int OK = 0, NO_ACCT = 1, BAD_PIN = 2, LOCKED = 3, INSUFF = 4, NO_DST = 5, BAD_AMT = 6, BAD_OP = 7;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0, req_ready;
  logic [2:0]    req_op = '0;
  logic [W-1:0]  req_acct = '0, req_pin = '0, req_dst = '0, req_amount = '0;
  logic          rsp_valid, rsp_ready = 1'b0;
  logic [2:0]    rsp_status;
  logic [W-1:0]  rsp_balance;
  logic          cfg_we = 1'b0;
  logic [IW-1:0] cfg_idx = '0;
  logic [W-1:0]  cfg_acct = '0, cfg_pin = '0, cfg_bal = '0;

  int n_cmp = 0;
  int n_fail = 0;

  account_server #(.NUM_ACCOUNTS(N), .REG_WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_acct(req_acct),
    .req_pin(req_pin), .req_dst(req_dst), .req_amount(req_amount),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status), .rsp_balance(rsp_balance),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_acct(cfg_acct), .cfg_pin(cfg_pin), .cfg_bal(cfg_bal)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(string name, int got, int exp);
    n_cmp++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Behavioural model: accounts as plain integer arrays
  bit m_valid[N];
  int m_acct[N], m_pin[N], m_bal[N], m_fails[N];
  bit m_lock[N];

  function automatic void m_reset();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 0; m_acct[i] = 0; m_pin[i] = 0; m_bal[i] = 0; m_fails[i] = 0; m_lock[i] = 0;
    end
  endfunction

  function automatic void m_cfg(int idx, int a, int p, int b);
    m_valid[idx] = 1; m_acct[idx] = a; m_pin[idx] = p; m_bal[idx] = b;
    m_fails[idx] = 0; m_lock[idx] = 0;
  endfunction

  function automatic int m_find(int a);
    for (int i = 0; i < N; i++)
      if (m_valid[i] && m_acct[i] == a) return i;
    return -1;
  endfunction

  function automatic void m_req(int op, int a, int p, int d, int amt, output int st, output int bal);
    int s, t;
    s = m_find(a);
    t = m_find(d);
    bal = 0;
    if (op > AU)              st = BAD_OP;
    else if (s < 0)           st = NO_ACCT;
    else if (m_lock[s])       st = LOCKED;
    else if (p != m_pin[s]) begin
      m_fails[s]++;
      if (m_fails[s] >= 3) begin m_lock[s] = 1; st = LOCKED; end
      else st = BAD_PIN;
    end else begin
      m_fails[s] = 0;
      if (amt == 0 && (op == DEP || op == WD || op == XF))        st = BAD_AMT;
      else if (op == XF && (t < 0 || t == s))                      st = NO_DST;
      else if ((op == WD || op == XF) && amt > m_bal[s])           st = INSUFF;
      else if (op == DEP && m_bal[s] + amt > MAXBAL)               st = BAD_AMT;
      else if (op == XF && m_bal[t] + amt > MAXBAL)                st = BAD_AMT;
      else begin
        st = OK;
        if (op == DEP) m_bal[s] += amt;
        if (op == WD)  m_bal[s] -= amt;
        if (op == XF) begin m_bal[s] -= amt; m_bal[t] += amt; end
        bal = m_bal[s];
      end
    end
  endfunction

  task automatic do_cfg(int idx, int a, int p, int b);
    @(negedge clk);
    cfg_we = 1'b1; cfg_idx = idx[IW-1:0]; cfg_acct = a[W-1:0]; cfg_pin = p[W-1:0]; cfg_bal = b[W-1:0];
    #1 check("req_ready_during_cfg", int'(req_ready), 0);
    @(posedge clk);
    #1 cfg_we = 1'b0;
  endtask

  task automatic do_req(string nm, int op, int a, int p, int d, int amt, int exp_st, int exp_bal, int hold);
    int lat;
    @(negedge clk);
    req_valid = 1'b1; req_op = op[2:0]; req_acct = a[W-1:0]; req_pin = p[W-1:0];
    req_dst = d[W-1:0]; req_amount = amt[W-1:0];
    #1 check({nm, ".req_ready"}, int'(req_ready), 1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (rsp_valid) begin lat = k; break; end
    end
    if (lat == 0) begin
      n_cmp++; n_fail++;
      $display("FAIL %s.timeout: got no rsp_valid, expected within 40 cycles", nm);
      return;
    end
    check({nm, ".latency"}, lat, LAT);
    check({nm, ".status"}, int'(rsp_status), exp_st);
    check({nm, ".balance"}, int'(rsp_balance), exp_bal);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      check({nm, ".hold_valid"}, int'(rsp_valid), 1);
      check({nm, ".hold_status"}, int'(rsp_status), exp_st);
      check({nm, ".hold_balance"}, int'(rsp_balance), exp_bal);
      check({nm, ".hold_req_ready"}, int'(req_ready), 0);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  typedef struct {
    bit is_cfg;
    int op, acct, pin, dst, amt, exp_st, exp_bal;
  } vec_t;
  vec_t tbl[$];

  function automatic void addv(bit c, int op, int a, int p, int d, int amt, int es, int eb);
    vec_t v;
    v.is_cfg = c; v.op = op; v.acct = a; v.pin = p; v.dst = d; v.amt = amt;
    v.exp_st = es; v.exp_bal = eb;
    tbl.push_back(v);
  endfunction

  task automatic reset_release(string nm);
    @(negedge clk);
    rst = 1'b1;
    #1 check({nm, ".req_ready_before_edge"}, int'(req_ready), 0);
    @(posedge clk);
    #1 check({nm, ".req_ready_after_edge"}, int'(req_ready), 1);
  endtask

  initial begin
    int st, bal, op, a, p, d, amt, r, s;
    int pool[6] = '{'h10, 'h11, 'h12, 'h13, 'h14, 'h15};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset.req_ready", int'(req_ready), 0);
    check("reset.rsp_valid", int'(rsp_valid), 0);
    check("reset.rsp_status", int'(rsp_status), 0);
    check("reset.rsp_balance", int'(rsp_balance), 0);
    reset_release("reset0");

    // Directed vectors: cfg rows use dst as slot index and amt as balance
    addv(1, 0,    'h123, 'h456, 0,     100, 0, 0);
    addv(0, DEP,  'h123, 'h456, 0,     20,  OK, 120);
    addv(0, WD,   'h123, 'h456, 0,     121, INSUFF, 0);
    addv(0, BAL,  'h123, 'h456, 0,     0,   OK, 120);
    addv(0, WD,   'h123, 'h456, 0,     120, OK, 0);
    addv(0, AU,   'h123, 'h000, 0,     0,   BAD_PIN, 0);
    addv(0, AU,   'h123, 'h000, 0,     0,   BAD_PIN, 0);
    addv(0, AU,   'h123, 'h000, 0,     0,   LOCKED, 0);
    addv(0, AU,   'h123, 'h456, 0,     0,   LOCKED, 0);
    addv(1, 0,    'h123, 'h456, 0,     50,  0, 0);
    addv(0, AU,   'h123, 'h456, 0,     0,   OK, 50);
    addv(1, 0,    'h789, 'h111, 1,     4090, 0, 0);
    addv(0, XF,   'h123, 'h456, 'h789, 10,  BAD_AMT, 0);
    addv(0, BAL,  'h789, 'h111, 0,     0,   OK, 4090);
    addv(0, BAL,  'h123, 'h456, 0,     0,   OK, 50);
    addv(0, XF,   'h123, 'h456, 'h789, 5,   OK, 45);
    addv(0, BAL,  'h789, 'h111, 0,     0,   OK, 4095);
    addv(0, 5,    'h123, 'h456, 0,     1,   BAD_OP, 0);
    addv(0, 6,    'hFFF, 'h456, 0,     1,   BAD_OP, 0);
    addv(0, BAL,  'hFFF, 'h456, 0,     0,   NO_ACCT, 0);
    addv(0, XF,   'h123, 'h456, 'h123, 1,   NO_DST, 0);
    addv(0, XF,   'h123, 'h456, 'h555, 1,   NO_DST, 0);
    addv(0, XF,   'h123, 'h456, 'h555, 0,   BAD_AMT, 0);
    addv(0, DEP,  'h123, 'h456, 0,     0,   BAD_AMT, 0);
    addv(0, DEP,  'h789, 'h111, 0,     1,   BAD_AMT, 0);
    addv(0, WD,   'h123, 'h000, 0,     1,   BAD_PIN, 0);
    addv(0, BAL,  'h123, 'h456, 0,     0,   OK, 45);
    addv(0, AU,   'h123, 'h000, 0,     0,   BAD_PIN, 0);
    addv(0, AU,   'h123, 'h000, 0,     0,   BAD_PIN, 0);
    addv(0, BAL,  'h123, 'h456, 0,     0,   OK, 45);
    addv(0, WD,   'h789, 'h111, 0,     4095, OK, 0);

    foreach (tbl[i]) begin
      if (tbl[i].is_cfg) do_cfg(tbl[i].dst, tbl[i].acct, tbl[i].pin, tbl[i].amt);
      else do_req($sformatf("vec%0d", i), tbl[i].op, tbl[i].acct, tbl[i].pin, tbl[i].dst,
                  tbl[i].amt, tbl[i].exp_st, tbl[i].exp_bal, 0);
    end

    // Response held while rsp_ready stays low
    do_req("hold", DEP, 'h123, 'h456, 0, 5, OK, 50, 3);

    // Reset asserted during LOOKUP drops the deposit
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'(DEP); req_acct = 'h123; req_pin = 'h456; req_amount = 'd7;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("midrst.req_ready", int'(req_ready), 0);
    check("midrst.rsp_valid", int'(rsp_valid), 0);
    check("midrst.rsp_status", int'(rsp_status), 0);
    check("midrst.rsp_balance", int'(rsp_balance), 0);
    repeat (20) begin
      @(posedge clk);
      #1;
      if (rsp_valid) break;
    end
    check("midrst.no_response", int'(rsp_valid), 0);
    reset_release("midrst");
    do_req("after_rst", BAL, 'h123, 'h456, 0, 0, NO_ACCT, 0, 0);

    // Randomized traffic against the model
    m_reset();
    for (int i = 0; i < N; i++) begin
      a = pool[$urandom_range(0, 5)];
      p = 'hA + int'($urandom_range(0, 1));
      bal = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, MAXBAL)) : MAXBAL - int'($urandom_range(0, 8));
      m_cfg(i, a, p, bal);
      do_cfg(i, a, p, bal);
    end
    for (int it = 0; it < 250; it++) begin
      if ($urandom_range(0, 9) == 0) begin
        s = int'($urandom_range(0, N - 1));
        a = pool[$urandom_range(0, 5)];
        p = 'hA + int'($urandom_range(0, 1));
        bal = int'($urandom_range(0, MAXBAL));
        m_cfg(s, a, p, bal);
        do_cfg(s, a, p, bal);
        continue;
      end
      r = int'($urandom_range(0, 9));
      case (r)
        0, 1: op = DEP;
        2, 3: op = WD;
        4:    op = BAL;
        5, 6: op = XF;
        7:    op = 5 + int'($urandom_range(0, 2));
        default: op = AU;
      endcase
      a = pool[$urandom_range(0, 5)];
      d = pool[$urandom_range(0, 5)];
      p = ($urandom_range(0, 3) == 0) ? 'hA + int'($urandom_range(0, 1)) : -1;
      s = m_find(a);
      if (p < 0) p = (s >= 0) ? m_pin[s] : 'hA;
      r = int'($urandom_range(0, 4));
      case (r)
        0: amt = 0;
        1: amt = int'($urandom_range(1, 40));
        2: amt = (s >= 0) ? m_bal[s] : 1;
        3: amt = (s >= 0 && m_bal[s] < MAXBAL) ? m_bal[s] + 1 : MAXBAL;
        default: amt = int'($urandom_range(0, MAXBAL));
      endcase
      m_req(op, a, p, d, amt, st, bal);
      do_req($sformatf("rnd%0d", it), op, a, p, d, amt, st, bal, int'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
